cla32_adder_reg: RTL and testbench

- 32-bit two's-complement adder built as a carry-lookahead adder (CLA) with a registered output stage, plus signed-overflow detection.
- Serves as the common registered adder core for the adder-comparison datapath. Its results must match a plain behavioural A+B+cin bit-for-bit.
- Combinational CLA tree feeds output registers clocked by clk.

---
 rtl/cla32_adder_reg.sv | 154 +++++++++++++++
 tb/tb_cla32_adder_reg.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/cla32_adder_reg.sv
`default_nettype none
// ============================================================================
//  Module   : cla32_adder_reg
//  Brief    : Two-level carry-lookahead adder with registered sum/cout/of.
//             Define CLA_INPUT_REG_EN to also register the operands (2-cycle latency).
//  Revision : 1.0 - initial release
// ============================================================================
module cla32_adder_reg #(
    parameter int WIDTH = 32,
    parameter int BLK   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             cin,
    output logic             out_valid,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             of
);

    localparam int c_NGRP = WIDTH / BLK;

    // AND of v[lo..hi]; an empty range yields 1.
    function automatic logic f_and_range(input logic [WIDTH-1:0] v, input int lo, input int hi);
        logic r;
        r = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            if (i >= lo && i <= hi) r = r & v[i];
        end
        return r;
    endfunction

    // Flattened lookahead: carry out of the first n positions given carry-in ci.
    function automatic logic f_lookahead(input logic [WIDTH-1:0] g, input logic [WIDTH-1:0] p,
                                         input logic ci, input int n);
        logic r;
        r = ci & f_and_range(p, 0, n - 1);
        for (int j = 0; j < WIDTH; j++) begin
            if (j < n) r = r | (g[j] & f_and_range(p, j + 1, n - 1));
        end
        return r;
    endfunction

    logic             w_vld_op;
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    logic             w_cin_op;

`ifdef CLA_INPUT_REG_EN
    logic             r_vld_in;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_cin;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld_in <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_cin    <= 1'b0;
        end else begin
            r_vld_in <= in_valid;
            r_a      <= A;
            r_b      <= B;
            r_cin    <= cin;
        end
    end

    assign w_vld_op = r_vld_in;
    assign w_a      = r_a;
    assign w_b      = r_b;
    assign w_cin_op = r_cin;
`else
    assign w_vld_op = in_valid;
    assign w_a      = A;
    assign w_b      = B;
    assign w_cin_op = cin;
`endif

    logic [WIDTH-1:0]  w_p;
    logic [WIDTH-1:0]  w_g;
    logic [WIDTH-1:0]  w_c;
    logic [WIDTH-1:0]  w_sum;
    logic [c_NGRP-1:0] w_gp;
    logic [c_NGRP-1:0] w_gg;
    logic [c_NGRP:0]   w_gc;
    logic              w_of;

    assign w_p = w_a ^ w_b;
    assign w_g = w_a & w_b;

    for (genvar gi = 0; gi < c_NGRP; gi++) begin : g_grp
        logic [BLK-1:0] w_bp;
        logic [BLK-1:0] w_bg;
        logic [BLK-1:0] w_bc;

        assign w_bp     = w_p[gi*BLK +: BLK];
        assign w_bg     = w_g[gi*BLK +: BLK];
        assign w_gp[gi] = &w_bp;
        assign w_gg[gi] = f_lookahead(WIDTH'(w_bg), WIDTH'(w_bp), 1'b0, BLK);

        // Bit carries inside the group come straight from the group carry-in.
        always_comb begin
            w_bc = '0;
            for (int b = 0; b < BLK; b++) begin
                w_bc[b] = f_lookahead(WIDTH'(w_bg), WIDTH'(w_bp), w_gc[gi], b);
            end
        end

        assign w_c[gi*BLK +: BLK] = w_bc;
    end

    // Second level: every group carry is a direct sum of products, no ripple.
    always_comb begin
        w_gc = '0;
        for (int k = 0; k <= c_NGRP; k++) begin
            w_gc[k] = f_lookahead(WIDTH'(w_gg), WIDTH'(w_gp), w_cin_op, k);
        end
    end

    assign w_sum = w_p ^ w_c;
    assign w_of  = (w_a[WIDTH-1] == w_b[WIDTH-1]) & (w_sum[WIDTH-1] != w_a[WIDTH-1]);

    logic             r_out_valid;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_of;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_of        <= 1'b0;
        end else begin
            r_out_valid <= w_vld_op;
            if (w_vld_op) begin
                r_sum  <= w_sum;
                r_cout <= w_gc[c_NGRP];
                r_of   <= w_of;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign of        = r_of;

endmodule
`default_nettype wire

// File: tb/tb_cla32_adder_reg.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cla32_adder_reg
//  Brief    : Self-checking bench: behavioural A+B+cin model plus directed cases.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cla32_adder_reg;

`ifdef CLA_INPUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] A        = '0;
    logic [31:0] B        = '0;
    logic        cin      = 1'b0;
    logic        out_valid;
    logic [31:0] sum;
    logic        cout;
    logic        of;

    always #5 clk = ~clk;

    cla32_adder_reg #(.WIDTH(32), .BLK(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .A         (A),
        .B         (B),
        .cin       (cin),
        .out_valid (out_valid),
        .sum       (sum),
        .cout      (cout),
        .of        (of)
    );

    typedef struct packed {
        logic        v;
        logic [31:0] s;
        logic        c;
        logic        o;
    } res_t;

    int n_tests = 0;
    int n_fail  = 0;
    bit cmp_en  = 1'b0;

    // Overflow taken from true signed range, not from sign bits.
    function automatic res_t ref_add(input logic [31:0] a, input logic [31:0] b,
                                     input logic ci, input logic v);
        res_t   r;
        logic [32:0] t;
        longint ls;
        t  = {1'b0, a} + {1'b0, b} + {32'd0, ci};
        ls = longint'($signed(a)) + longint'($signed(b)) + longint'(ci);
        r.v = v;
        r.s = t[31:0];
        r.c = t[32];
        r.o = (ls > 64'sd2147483647) || (ls < -64'sd2147483648);
        return r;
    endfunction

    res_t        pipe[$];
    res_t        m_head;
    logic        m_valid = 1'b0;
    logic [31:0] m_sum   = '0;
    logic        m_cout  = 1'b0;
    logic        m_of    = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe.delete();
            for (int i = 0; i < LAT - 1; i++) pipe.push_back('0);
            m_valid = 1'b0;
            m_sum   = '0;
            m_cout  = 1'b0;
            m_of    = 1'b0;
        end else begin
            pipe.push_back(ref_add(A, B, cin, in_valid));
            if (pipe.size() > LAT - 1) begin
                m_head  = pipe.pop_front();
                m_valid = m_head.v;
                if (m_head.v) begin
                    m_sum  = m_head.s;
                    m_cout = m_head.c;
                    m_of   = m_head.o;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            n_tests++;
            if ({out_valid, sum, cout, of} !== {m_valid, m_sum, m_cout, m_of}) begin
                n_fail++;
                $display("FAIL model_cmp t=%0t: got v=%b s=%h c=%b o=%b, expected v=%b s=%h c=%b o=%b",
                         $time, out_valid, sum, cout, of, m_valid, m_sum, m_cout, m_of);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic setv(input logic [31:0] a, input logic [31:0] b, input logic c, input logic v);
        A        = a;
        B        = b;
        cin      = c;
        in_valid = v;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_lit(input string tag, input logic [31:0] es, input logic ec, input logic eo);
        repeat (LAT) @(posedge clk);
        #1;
        check({tag, ".valid"}, 32'(out_valid), 32'd1);
        check({tag, ".sum"},   sum,            es);
        check({tag, ".cout"},  32'(cout),      32'(ec));
        check({tag, ".of"},    32'(of),        32'(eo));
    endtask

    function automatic logic [31:0] rand_op();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    res_t pin;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst.valid", 32'(out_valid), 32'd0);
        check("rst.sum",   sum,            32'd0);
        check("rst.cout",  32'(cout),      32'd0);
        check("rst.of",    32'(of),        32'd0);

        pin = ref_add(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1);
        check("model_pin.ovf", {pin.s[31:1], pin.o}, {31'h4000_0000, 1'b1});
        pin = ref_add(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1);
        check("model_pin.carry", {pin.s[31:1], pin.c}, {31'h7FFF_FFFF, 1'b1});

        rst_n  = 1'b1;
        cmp_en = 1'b1;
        step();

        // Back-to-back directed vectors, each with its own literal expectation.
        setv(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1);
        fork expect_lit("pos_ovf", 32'h8000_0000, 1'b0, 1'b1); join_none
        step();
        setv(32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1'b1);
        fork expect_lit("neg_ovf", 32'h7FFF_FFFF, 1'b1, 1'b1); join_none
        step();
        setv(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1);
        fork expect_lit("mixed_sign", 32'h7FFF_FFFE, 1'b1, 1'b0); join_none
        step();
        setv(32'h0000_0001, 32'h8000_0000, 1'b0, 1'b1);
        fork expect_lit("b2b", 32'h8000_0001, 1'b0, 1'b0); join_none
        step();
        setv(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1);
        fork expect_lit("all_ones_cin", 32'hFFFF_FFFF, 1'b1, 1'b0); join_none
        step();
        setv(32'h0000_FFFF, 32'h00FF_0000, 1'b1, 1'b1);
        fork expect_lit("grp_carry", 32'h0100_0000, 1'b0, 1'b0); join_none
        step();

        setv(32'h0, 32'h0, 1'b0, 1'b0);
        repeat (LAT + 2) step();
        check("hold.valid", 32'(out_valid), 32'd0);
        check("hold.sum",   sum,            32'h0100_0000);
        check("hold.cout",  32'(cout),      32'd0);

        // Asynchronous reset between edges while results are in flight.
        setv(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b1);
        repeat (LAT) step();
        check("pre_rst.valid", 32'(out_valid), 32'd1);
        check("pre_rst.sum",   sum,            32'h2345_6789);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        setv(32'h0, 32'h0, 1'b0, 1'b0);
        #1;
        check("async_rst.valid", 32'(out_valid), 32'd0);
        check("async_rst.sum",   sum,            32'd0);
        check("async_rst.cout",  32'(cout),      32'd0);
        check("async_rst.of",    32'(of),        32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (LAT + 1) step();
        check("post_rst.valid", 32'(out_valid), 32'd0);
        check("post_rst.sum",   sum,            32'd0);

        for (int n = 0; n < 10000; n++) begin
            setv(rand_op(), rand_op(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 4) != 0));
            if ($urandom_range(0, 999) == 0) begin
                #2;
                rst_n = 1'b0;
                #1;
                rst_n = 1'b1;
            end
            step();
        end

        setv(32'h0, 32'h0, 1'b0, 1'b0);
        repeat (LAT + 2) step();
        cmp_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
